xor_accum: RTL and testbench

XOR_ACCUM -- requirements
Module: xor_accum

---
 rtl/xor_accum_pkg.sv | 7 +
 rtl/xor_accum_xor_word.sv | 10 +
 rtl/xor_accum.sv | 80 ++++++++
 tb/tb_xor_accum.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/xor_accum_pkg.sv
// xor_accum_pkg: shared state encoding and counter sizing for xor_accum.
package xor_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/xor_accum_xor_word.sv
// xor_word: combinational bitwise XOR of two WIDTH-bit words.
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/xor_accum.sv
// xor_accum: XORs A^B beats over FRAME_LEN-beat frames and holds the result until taken.
// Defining XOR_ACCUM_CLEAR_EN adds a synchronous clear port that aborts the current frame.
module xor_accum
  import xor_accum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef XOR_ACCUM_CLEAR_EN
  input  logic             clear,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] acc,
  output logic             parity,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);
  state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, x;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_valid_q, q_valid_d, clr, take;
`ifdef XOR_ACCUM_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif
  xor_word #(.WIDTH(WIDTH)) u_xor (.a(a), .b(b), .y(x));
  assign in_ready  = (state_q != HOLD) && !clr;
  assign take      = in_valid && in_ready;
  assign out_valid = state_q == HOLD;
  // mid-frame accumulator stays hidden until the frame completes
  assign acc       = out_valid ? acc_q : '0;
  assign parity    = ^acc;
  assign q         = q_q;
  assign q_valid   = q_valid_q;
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    q_d       = take ? x : q_q;
    q_valid_d = take;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == HOLD) begin
      state_d = out_ready ? IDLE : HOLD;
      acc_d   = out_ready ? '0 : acc_q;
      cnt_d   = out_ready ? '0 : cnt_q;
    end else if (take) begin
      acc_d   = (state_q == IDLE) ? x : acc_q ^ x;
      cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + 1'b1;
      state_d = (cnt_d == LAST) ? HOLD : ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end
endmodule

// File: tb/tb_xor_accum.sv
// tb_xor_accum: randomized and directed checks of xor_accum against a frame-queue reference model.
module tb_xor_accum;
  localparam int W  = 8;
  localparam int FL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [W-1:0] a = '0, b = '0, q, acc;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, q_valid, out_valid, parity;
  logic [15:0] a1 = '0, b1 = '0, q1, acc1;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0, in_ready1, q_valid1, out_valid1, parity1;
`ifdef XOR_ACCUM_CLEAR_EN
  logic clear = 1'b0, clear1 = 1'b0;
`endif
  xor_accum #(.WIDTH(W), .FRAME_LEN(FL)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef XOR_ACCUM_CLEAR_EN
    .clear(clear),
`endif
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready), .q(q), .q_valid(q_valid),
    .acc(acc), .parity(parity), .out_valid(out_valid), .out_ready(out_ready)
  );
  xor_accum #(.WIDTH(16), .FRAME_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef XOR_ACCUM_CLEAR_EN
    .clear(clear1),
`endif
    .a(a1), .b(b1), .in_valid(in_valid1), .in_ready(in_ready1), .q(q1), .q_valid(q_valid1),
    .acc(acc1), .parity(parity1), .out_valid(out_valid1), .out_ready(out_ready1)
  );
  int n_chk = 0;
  int n_err = 0;
  // reference model: the accepted beats of the current frame, plus the last Q
  logic [W-1:0] beats[$];
  logic [W-1:0] m_q = '0;
  logic m_qv = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] m_acc();
    logic [W-1:0] r;
    r = '0;
    if (beats.size() != FL) return '0;
    foreach (beats[i]) r ^= beats[i];
    return r;
  endfunction
  task automatic check_outs();
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("out_valid", 32'(out_valid), 32'(beats.size() == FL));
    chk("acc", 32'(acc), 32'(m_acc()));
    chk("parity", 32'(parity), 32'(^m_acc()));
  endtask
  task automatic cycle(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ordy, input logic clr);
    logic c;
    c = 1'b0;
    in_valid = v; a = aa; b = bb; out_ready = ordy;
`ifdef XOR_ACCUM_CLEAR_EN
    clear = clr;
    c = clr;
`endif
    #1 chk("in_ready", 32'(in_ready), 32'((beats.size() != FL) && !c));
    @(posedge clk);
    if (c) begin
      beats.delete();
      m_qv = 1'b0;
    end else if (beats.size() == FL) begin
      m_qv = 1'b0;
      if (ordy) beats.delete();
    end else if (v) begin
      m_q = aa ^ bb;
      m_qv = 1'b1;
      beats.push_back(aa ^ bb);
    end else m_qv = 1'b0;
    @(negedge clk);
    check_outs();
  endtask
  task automatic frame31(input logic gapped);
    cycle(1, 8'h0F, 8'hF0, 0, 0); if (gapped) cycle(0, 8'h33, 8'h11, 0, 0);
    cycle(1, 8'hAA, 8'h00, 0, 0); if (gapped) cycle(0, 8'h33, 8'h11, 0, 0);
    cycle(1, 8'h55, 8'h55, 0, 0); if (gapped) cycle(0, 8'h33, 8'h11, 0, 0);
    cycle(1, 8'h01, 8'h00, 0, 0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_par", 32'(parity), 0);
    rst_n = 1'b1;
    frame31(0);
    chk("acc_54", 32'(acc), 32'h54);
    chk("par_54", 32'(parity), 1);
    repeat (3) begin
      cycle(1, 8'h12, 8'h34, 0, 0);
      chk("hold_acc", 32'(acc), 32'h54);
    end
    cycle(1, 8'h11, 8'h22, 1, 0);
    chk("release_no_beat", 32'(q_valid), 0);
    frame31(1);
    chk("gapped_acc", 32'(acc), 32'h54);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 8'h01, 8'h02, 0, 0);
    cycle(1, 8'h03, 8'h04, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 0);
    chk("arst_qv", 32'(q_valid), 0);
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_acc", 32'(acc), 0);
    beats.delete();
    m_q = '0;
    m_qv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1, 8'h80, 8'h00, 0, 0);
    chk("no_ov_after_rst", 32'(out_valid), 0);
    cycle(1, 8'h80, 8'h00, 0, 0);
    chk("acc_80", 32'(acc), 0);
    chk("par_80", 32'(parity), 0);
    cycle(0, 0, 0, 1, 0);
`ifdef XOR_ACCUM_CLEAR_EN
    cycle(1, 8'h0F, 8'h00, 0, 0);
    cycle(1, 8'hF0, 8'h00, 0, 0);
    cycle(1, 8'hFF, 8'h00, 0, 1);
    chk("clr_qv", 32'(q_valid), 0);
    frame31(0);
    chk("clr_acc", 32'(acc), 32'h54);
    cycle(0, 0, 0, 1, 0);
`endif
    repeat (400)
      cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    in_valid1 = 1'b1; a1 = 16'h1234; b1 = 16'h00FF;
    #1 chk("d1_ready", 32'(in_ready1), 1);
    @(negedge clk);
    chk("d1_q", 32'(q1), 32'h12CB);
    chk("d1_qv", 32'(q_valid1), 1);
    chk("d1_ov", 32'(out_valid1), 1);
    chk("d1_acc", 32'(acc1), 32'h12CB);
    chk("d1_par", 32'(parity1), 1);
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    @(negedge clk);
    chk("d1_ov_clr", 32'(out_valid1), 0);
    chk("d1_acc_clr", 32'(acc1), 0);
    chk("d1_qv_clr", 32'(q_valid1), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
